// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// The product/quotient is formed at issue into a pending register. The
// accumulate step (madd/msub) is applied at the completion edge, so it
// always uses HI/LO as they stand at the write edge.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [3:0]           op_lat;
    logic [WIDTH-1:0]     a_lat, b_lat;
    logic [2*WIDTH-1:0]   pending;

    logic                 is_multi, is_div, accept, done;
    logic [2*WIDTH-1:0]   issue_res, wb_val;
    logic                 wb_en;

    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          a_mag, b_mag, q_mag, r_mag, q_s, r_s, divisor_u, q_u, r_u;

    assign busy  = (state == S_BUSY);
    assign stall = busy | (start & is_multi);

    // Classify the presented op and decide whether this edge accepts it.
    always_comb begin
        is_multi = 1'b0;
        is_div   = 1'b0;
        case (md_op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_multi = 1'b1;
                is_div   = 1'b1;
            end
            default: is_multi = 1'b0;
        endcase
        accept = start & (state == S_IDLE);
    end

    // Issue-time arithmetic: signed/unsigned products and divisions
    // (signed division via magnitudes, so min/-1 wraps to min without a trap).
    always_comb begin
        prod_s    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        a_mag     = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag     = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        if (b_mag == {WIDTH{1'b0}}) begin
            q_mag = {WIDTH{1'b0}};
            r_mag = {WIDTH{1'b0}};
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        q_s       = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~q_mag + WIDTH'(1)) : q_mag;
        r_s       = a[WIDTH-1] ? (~r_mag + WIDTH'(1)) : r_mag;
        divisor_u = (b == {WIDTH{1'b0}}) ? WIDTH'(1) : b;
        q_u       = a / divisor_u;
        r_u       = a % divisor_u;
        case (md_op)
            OP_MULT, OP_MADD, OP_MSUB:    issue_res = prod_s;
            OP_MULTU, OP_MADDU, OP_MSUBU: issue_res = prod_u;
            OP_DIV:                       issue_res = {r_s, q_s};
            OP_DIVU:                      issue_res = {r_u, q_u};
            default:                      issue_res = {2*WIDTH{1'b0}};
        endcase
    end

    // Completion write-back value; divide by zero leaves HI/LO untouched.
    always_comb begin
        wb_en  = 1'b0;
        wb_val = {hi, lo};
        case (op_lat)
            OP_MULT, OP_MULTU: begin
                wb_en  = 1'b1;
                wb_val = pending;
            end
            OP_DIV, OP_DIVU: begin
                wb_en  = (b_lat != {WIDTH{1'b0}});
                wb_val = pending;
            end
            OP_MADD, OP_MADDU: begin
                wb_en  = 1'b1;
                wb_val = {hi, lo} + pending;
            end
            OP_MSUB, OP_MSUBU: begin
                wb_en  = 1'b1;
                wb_val = {hi, lo} - pending;
            end
            default: begin
                wb_en  = 1'b0;
                wb_val = {hi, lo};
            end
        endcase
    end

    // Next-state logic: load the busy counter at issue, count down, finish at 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_multi) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end else begin
                    state_nxt = S_BUSY;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= {CNT_W{1'b0}};
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operand/result latches and HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_lat  <= 4'd0;
            a_lat   <= {WIDTH{1'b0}};
            b_lat   <= {WIDTH{1'b0}};
            pending <= {2*WIDTH{1'b0}};
            hi      <= {WIDTH{1'b0}};
            lo      <= {WIDTH{1'b0}};
        end else begin
            if (accept && is_multi) begin
                op_lat  <= md_op;
                a_lat   <= a;
                b_lat   <= b;
                pending <= issue_res;
            end
            if (accept && (md_op == OP_MTHI)) begin
                hi <= a;
            end
            if (accept && (md_op == OP_MTLO)) begin
                lo <= a;
            end
            if (done && wb_en) begin
                {hi, lo} <= wb_val;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: table of directed ops plus hand-written
// sequences for ignored starts, reset abort, back-to-back issue and N=1.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset, start, start1;
    logic [3:0]  md_op, md_op1;
    logic [31:0] a, b, a1, b1;
    logic        busy, stall, busy1, stall1;
    logic [31:0] hi, lo, hi1, lo1;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo));

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .md_op(md_op1), .a(a1), .b(b1),
        .busy(busy1), .stall(stall1), .hi(hi1), .lo(lo1));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_stall(input logic [3:0] op);
        return (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10});
    endfunction

    // Issue one op in the next cycle, then count busy cycles and check HI/LO.
    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int n,
                         input logic [31:0] ehi, input logic [31:0] elo);
        int cnt;
        @(negedge clk);
        start = 1'b1; md_op = op; a = av; b = bv;
        #1;
        check({name, "_stall"}, {63'd0, stall}, {63'd0, exp_stall(op)});
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        check({name, "_busy_cycles"}, 64'(cnt), 64'(n));
        check({name, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, elo});
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{4'd1,  32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{4'd3,  32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd4,  32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{4'd5,  32'h00000000, 32'h00000000, 0,  32'h00000000, 32'hFFFFFFFD};
        vecs[5]  = '{4'd6,  32'hFFFFFFFF, 32'h00000000, 0,  32'h00000000, 32'hFFFFFFFF};
        vecs[6]  = '{4'd7,  32'h00000001, 32'h00000001, 5,  32'h00000001, 32'h00000000};
        vecs[7]  = '{4'd10, 32'h00000001, 32'h00000002, 5,  32'h00000000, 32'hFFFFFFFE};
        vecs[8]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[9]  = '{4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h80000001};
        vecs[10] = '{4'd9,  32'h00000003, 32'hFFFFFFFE, 5,  32'hFFFFFFFE, 32'h80000007};
        vecs[11] = '{4'd3,  32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[12] = '{4'd3,  32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003};
        vecs[13] = '{4'd11, 32'h00000005, 32'h00000005, 0,  32'hFFFFFFFF, 32'h00000003};
        vecs[14] = '{4'd6,  32'h12345678, 32'h00000000, 0,  32'hFFFFFFFF, 32'h12345678};

        reset = 1'b1; start = 1'b0; md_op = 4'd0; a = 32'd0; b = 32'd0;
        start1 = 1'b0; md_op1 = 4'd0; a1 = 32'd0; b1 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].n, vecs[i].hi, vecs[i].lo);
        end

        // Starts presented while a div is in flight are ignored.
        do_op("pre_mthi", 4'd5, 32'h55, 32'd0, 0, 32'h55, 32'h12345678);
        do_op("pre_mtlo", 4'd6, 32'h66, 32'd0, 0, 32'h55, 32'h66);
        @(negedge clk);
        start = 1'b1; md_op = 4'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (cnt == 3) begin
                start = 1'b1; md_op = 4'd1; a = 32'd9; b = 32'd9;
                #1;
                check("ign_stall", {63'd0, stall}, 64'd1);
            end else if (cnt == 4) begin
                start = 1'b1; md_op = 4'd5; a = 32'hAAAA;
            end else begin
                start = 1'b0; md_op = 4'd0;
            end
            if (cnt == 5) check("ign_mthi", {32'd0, hi}, 64'h55);
            @(posedge clk); #1;
        end
        start = 1'b0; md_op = 4'd0;
        check("ign_busy_cycles", 64'(cnt), 64'd10);
        check("ign_result", {hi, lo}, {32'd2, 32'd14});

        // Reset in the middle of a mult aborts it.
        @(negedge clk);
        start = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_write", {hi, lo}, 64'd0);
        check("abort_busy_late", {63'd0, busy}, 64'd0);

        // Back-to-back: divu issued in the first cycle after multu completes.
        do_op("b2b_multu", 4'd2, 32'd3, 32'd4, 5, 32'd0, 32'd12);
        do_op("b2b_divu", 4'd4, 32'd12, 32'd5, 10, 32'd2, 32'd2);

        // N=1 instance: busy for exactly one cycle.
        @(negedge clk);
        start1 = 1'b1; md_op1 = 4'd1; a1 = 32'd3; b1 = 32'd5;
        @(posedge clk); #1;
        start1 = 1'b0; md_op1 = 4'd0;
        check("n1_mult_busy", {63'd0, busy1}, 64'd1);
        @(posedge clk); #1;
        check("n1_mult_done", {63'd0, busy1}, 64'd0);
        check("n1_mult_res", {hi1, lo1}, {32'd0, 32'd15});
        @(negedge clk);
        start1 = 1'b1; md_op1 = 4'd4; a1 = 32'd20; b1 = 32'd3;
        @(posedge clk); #1;
        start1 = 1'b0; md_op1 = 4'd0;
        check("n1_div_busy", {63'd0, busy1}, 64'd1);
        @(posedge clk); #1;
        check("n1_div_done", {63'd0, busy1}, 64'd0);
        check("n1_div_res", {hi1, lo1}, {32'd2, 32'd6});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the E stage of the pipelined MIPS core; sits beside the ALU.
- Owns the HI/LO architectural registers and executes the following ops: mult, multu, div, divu, madd, maddu, msub, msubu, mthi, mtlo.
- Exposes a busy/stall interface so the hazard unit can freeze D/E while an operation is in flight.
- Operands arrive already forwarded (the same p1/p2 values the ALU consumes).

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe from E stage; qualifies md_op.
- md_op  input  4  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 treated as none.
- a  input  WIDTH  rs operand (forwarded).
- b  input  WIDTH  rt operand (forwarded).
- busy  output  1  registered; high while a multi-cycle op is in flight.
- stall  output  1  combinational: busy OR (start AND md_op in {1,2,3,4,7,8,9,10}). The hazard unit uses this to hold any mfhi/mflo/md instruction in D.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, cycle counter=0, latched op/operands=0.
  - Reset mid-operation aborts the operation; HI/LO are not written by it.
- Issue acceptance: issue is accepted at a rising edge when start=1, busy=0 and reset=0. Starts presented while busy=1 are ignored; no queueing.
- mthi / mtlo: single-cycle.
  - At the accepting edge: hi<=a (mthi) or lo<=a (mtlo).
  - busy stays 0.
- Multi-cycle ops: at the accepting edge T:
  - latch op, a and b;
  - compute the result into an internal 2*WIDTH pending register. The result may be computed combinationally at issue or iteratively; the externally visible timing must be identical either way;
  - load counter with N (N = MULT_CYCLES or DIV_CYCLES);
  - busy<=1.
- Each following edge decrements the counter. At the edge where the counter goes 1->0:
  - {hi,lo} are written;
  - busy<=0.
- Net timing: busy is high for exactly N cycles (T+1 .. T+N). New hi/lo are visible in the first cycle busy=0. A new start is acceptable in that same cycle.
- Arithmetic rules:
  - mult: {hi,lo} = signed(a)*signed(b), full 2*WIDTH product.
  - multu: unsigned product.
  - madd/maddu: {hi,lo} = {hi,lo} + product (signed/unsigned product). 2*WIDTH addition with wrap, no overflow flag. Uses hi/lo as they are at the write edge.
  - msub/msubu: {hi,lo} = {hi,lo} - product, with wrap.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary conditions:
  - Divide by zero (b==0, div or divu): still busy for DIV_CYCLES; hi/lo unchanged at completion.
  - Signed div of the most negative value by -1 (a=1<<(WIDTH-1), b=-1): lo=a, hi=0. No trap.
  - N=1: busy high for exactly one cycle.
  - Operand changes on a/b while busy have no effect on the result.
- Output properties: hi/lo change only on an accepted mthi/mtlo edge or on a completion edge. Outputs are never X after reset.

Test Plan (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10):
- mult with a=0xFFFFFFFF, b=0x00000002.
  - Required: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Same operands with multu: hi=0x00000001, lo=0xFFFFFFFE.
- div with a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - divu with a=7, b=0 -> hi/lo unchanged, busy still 10 cycles.
- Sequence: mthi 0, then mtlo 0xFFFFFFFF, then madd a=1, b=1 -> hi=0x00000001, lo=0x00000000.
  - Follow with msubu a=1, b=2 -> hi=0x00000000, lo=0xFFFFFFFE.
- Start div, then at busy cycle 3 pulse start with mult and also mthi -> both ignored; final div result correct; busy total exactly 10.
- Start mult (busy=1), assert reset at busy cycle 2 -> next cycle busy=0, hi=0, lo=0; no later write from the aborted op.
- Back-to-back: start multu 3*4 and re-issue divu 12/5 in the first cycle busy=0.
  - Required: hi:lo = 0:12 visible at that cycle; then hi=2, lo=2 after 10 more cycles.
  - stall is high combinationally in both issue cycles.
